// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-enable data memory behind a req/gnt/rvalid bus port.
//  - One access per accepted cycle, response exactly one cycle later.
//  - Reads are registered; writes return rdata=0.
//  - Accesses whose word index is >= DEPTH_WORDS respond with err=1, rdata=0
//    and leave the array untouched.
//  - Optional feature macro: DMEM_CLEAR_EN. When defined, every reset is
//    followed by a zero-clear sweep over the whole array (busy_o=1, gnt_o=0).
//    When undefined, the block is always ready and the array powers up
//    undefined.
module data_mem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFS_W  = $clog2(BE_W);
  localparam int unsigned IDX_W  = ADDR_W - OFS_W;
  localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Storage array; intentionally never reset.
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              run;
  logic              accept;
  logic              wr_en;
  logic              clr_we;
  logic [MEM_AW-1:0] clr_addr;
  logic              unused_ofs;

  assign idx        = addr_i[ADDR_W-1:OFS_W];
  assign mem_idx    = idx[MEM_AW-1:0];
  assign unused_ofs = ^addr_i[OFS_W-1:0];

  // Range check done at 32 bits so a DEPTH_WORDS that fills the index space
  // and one that does not are handled by the same comparison.
  assign in_range = ({{(32-IDX_W){1'b0}}, idx} < DEPTH_WORDS);

  assign gnt_o  = req_i & run;
  assign accept = gnt_o;
  assign wr_en  = accept & we_i & in_range;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_t;

  localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(DEPTH_WORDS - 1);

  state_t            state;
  logic [MEM_AW-1:0] clr_idx;

  // Clear sequencer: sweep every word once after reset, then hand over to RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      busy_o  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state  <= ST_RUN;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign run      = (state == ST_RUN);
  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = clr_idx;
`else
  assign run      = 1'b1;
  assign busy_o   = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Array write port: clear sweep has priority; bus writes merge enabled lanes.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (be_i[k]) begin
          mem[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response stage: one-cycle registered read, error flag, and valid strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= accept;
      err_o    <= accept & ~in_range;
      if (accept) begin
        if (!we_i && in_range) begin
          rdata_o <= mem[mem_idx];
        end else begin
          rdata_o <= '0;
        end
      end
    end
  end

endmodule
